btn_event_arbiter: RTL

Collects rising edges from N debounced button levels, latches each press as a pending event, and hands events one at a time to the game controller over a valid/ready handshake. Grants are round-robin across buttons, with a programmable hold-off gap between events. It sits between the per-button debounce filters and the whack-a-mole game FSM, so the FSM sees exactly one clean event per press.

---
 rtl/btn_event_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/btn_event_arbiter.sv
// -----------------------------------------------------------------------------
// btn_event_arbiter
//
// Turns debounced button levels into one clean event per press for the
// whack-a-mole game FSM.
//
//   * Each button has a rising-edge detector.
//   * A detected press sets that button's pending bit.
//   * A round-robin arbiter picks one pending button at a time.
//   * The chosen button is offered on a valid/ready handshake.
//   * After every accepted event, a hold-off counter forces HOLDOFF idle
//     cycles before the next event may load.
//
// Parameters
//   N_BTN    number of buttons (2..16)
//   ID_W     width of evt_id; the integrator guarantees 2**ID_W >= N_BTN
//   HOLDOFF  idle cycles enforced after each accepted event (0..2**20-1)
//
// Ports
//   clk         system clock
//   rst_n       asynchronous, active-low reset
//   btn_level   debounced button levels, synchronous to clk, active-high
//   enable      1: latch new presses; 0: ignore presses and flush pending
//   evt_ready   consumer accepts the offered event while evt_valid is high
//   evt_valid   an event is being offered (registered)
//   evt_id      index of the offered button; meaningful only with evt_valid
//   pending     latched presses not yet issued (registered)
//   drop_pulse  one-cycle pulse when a press merges into an existing
//               pending bit (registered)
//
// All outputs come straight from flops. There is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module btn_event_arbiter #(
  parameter int unsigned N_BTN   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned HOLDOFF = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_level,
  input  logic             enable,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  output logic [N_BTN-1:0] pending,
  output logic             drop_pulse
);

  // The hold-off counter is sized for the full HOLDOFF range, so changing
  // HOLDOFF never changes the datapath width.
  localparam int unsigned      CNT_W      = 20;
  localparam logic [CNT_W-1:0] HOLDOFF_LD = CNT_W'(HOLDOFF);

  // After reset the pointer sits on the last button. The upward scan from
  // last_ptr+1 therefore starts at button 0.
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_BTN - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] prev;      // btn_level sampled on the previous cycle
  logic [ID_W-1:0]  last_ptr;  // id of the most recently accepted event
  logic [CNT_W-1:0] hold_cnt;  // remaining hold-off cycles

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0]   rise;
  logic [2*N_BTN-1:0] dbl;
  logic [N_BTN-1:0]   rot;
  logic [ID_W:0]      base;
  int                 off;
  int                 sum;
  logic [ID_W-1:0]    sel;
  logic               sel_found;
  logic               load;
  logic               handshake;
  logic [N_BTN-1:0]   clr_mask;
  logic [N_BTN-1:0]   pending_nxt;
  logic               coalesce;

  // Falling edges are deliberately ignored.
  // prev keeps sampling while enable is low. A button that is already held
  // when enable returns therefore produces no rise, and so no event.
  assign rise = btn_level & ~prev;

  // Round-robin selection.
  //
  // Put two copies of pending side by side, then shift right by last_ptr+1.
  // Bit k of the low half is then the button at (last_ptr+1+k) mod N_BTN.
  // The lowest set bit of that window is the next button in scan order.
  //
  // base is one bit wider than last_ptr, so last_ptr+1 cannot wrap when
  // N_BTN == 2**ID_W.
  assign base = {1'b0, last_ptr} + 1'b1;
  assign dbl  = {pending, pending} >> base;
  assign rot  = dbl[N_BTN-1:0];

  // NOTE: every signal written in this block gets a default before any
  // conditional code. Without the defaults, paths that skip an assignment
  // would infer latches.
  always_comb begin
    off       = 0;
    sel_found = 1'b0;
    // Scanning downward and letting the last hit win leaves the lowest
    // set offset in off.
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off       = k;
        sel_found = 1'b1;
      end
    end
    // Map the offset back to a button index. The sum is at most
    // 2*N_BTN-1, so a single conditional subtraction is enough.
    sum = int'(last_ptr) + 1 + off;
    if (sum >= int'(N_BTN)) begin
      sum = sum - int'(N_BTN);
    end
    sel = ID_W'(sum);
  end

  // A new event loads only when:
  //   * the output slot is empty,
  //   * the hold-off gap has expired, and
  //   * at least one press is waiting.
  assign load      = ~evt_valid & (hold_cnt == '0) & sel_found;
  assign handshake = evt_valid & evt_ready;

  // The chosen button is cleared in the same cycle it is loaded.
  assign clr_mask  = load ? (N_BTN'(1) << sel) : '0;

  // Pending update.
  //   * The clear is applied before the rise is merged in. A rise on the
  //     button being loaded therefore re-arms it as a fresh event rather
  //     than counting as a merged press.
  //   * While enable is low, nothing is latched and everything pending is
  //     flushed.
  always_comb begin
    pending_nxt = '0;
    if (enable) begin
      pending_nxt = (pending & ~clr_mask) | rise;
    end
  end

  // A press merges when its button already has a pending bit that is not
  // being cleared this cycle. One pulse covers any number of merging
  // buttons in the same cycle.
  assign coalesce = enable & |(rise & pending & ~clr_mask);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments. Every flop then
  // samples pre-edge values, whatever the order of the statements.
  // NOTE: every flop here, including the pending vector, has an explicit
  // reset value. Reset anywhere in a handshake must leave nothing on the
  // interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      pending    <= '0;
      drop_pulse <= 1'b0;
    end else begin
      prev       <= btn_level;
      pending    <= pending_nxt;
      drop_pulse <= coalesce;
    end
  end

  // Output slot.
  // Once loaded, an event is held unchanged until it is accepted. It is
  // never withdrawn, even if enable drops while it is being offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
    end else if (load) begin
      evt_valid <= 1'b1;
      evt_id    <= sel;
    end else if (handshake) begin
      evt_valid <= 1'b0;
    end
  end

  // Fairness pointer and hold-off gap, both updated by an accepted event.
  //
  // The counter is reloaded on the handshake edge. load only fires once it
  // reads zero. The next event is therefore visible HOLDOFF+2 cycles after
  // the handshake cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ptr <= LAST_RST;
      hold_cnt <= '0;
    end else if (handshake) begin
      last_ptr <= evt_id;
      hold_cnt <= HOLDOFF_LD;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - CNT_W'(1);
    end
  end

endmodule
